set_assoc_cache: RTL and testbench

Parametrised N-way set-associative, write-back, write-allocate cache controller with per-set age-based LRU replacement and a handshaked word-wide backing-memory port. It is the successor to the fixed 256-line direct-mapped cache. The processor-side request/response port replaces the old comp/write/t_in control with a single valid/ready handshake. The block sits between the core's load/store path and the 8192×16 main memory, and WAYS=1 gives direct-mapped behaviour.

---
 rtl/set_assoc_cache.sv | 241 ++++++++++++++++++++++++
 tb/tb_set_assoc_cache.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/set_assoc_cache.sv
// N-way set-associative, write-back / write-allocate cache with age-based LRU
// and a registered, word-wide valid/ready backing-memory port.
module set_assoc_cache #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16,
  parameter int WORDS  = 4,
  parameter int SETS   = 64,
  parameter int WAYS   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_hit,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int OW = $clog2(WORDS);
  localparam int IW = $clog2(SETS);
  localparam int TW = ADDR_W - IW - OW;
  localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef logic [WAYS-1:0][WW-1:0] age_row_t;

  function automatic age_row_t age_reset_row();
    age_row_t r;
    for (int w = 0; w < WAYS; w++) r[w] = WW'(w);
    return r;
  endfunction

  localparam age_row_t AGE_ROW = age_reset_row();

  // Valid/ready: a request or memory beat transfers on the rising edge where
  // both valid and ready are high; the initiator holds its payload until then.
  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, FILL, UPDATE} state_t;
  state_t state, state_nxt;

  logic [SETS-1:0][WAYS-1:0]         line_valid;
  logic [SETS-1:0][WAYS-1:0]         line_dirty;
  logic [SETS-1:0][WAYS-1:0][WW-1:0] line_age;
  logic [TW-1:0]                     line_tag  [SETS][WAYS];
  logic [DATA_W-1:0]                 line_data [SETS][WAYS][WORDS];

  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;
  logic [TW-1:0]     req_tag;
  logic [IW-1:0]     req_idx;
  logic [OW-1:0]     req_off;

  logic          hit;
  logic [WW-1:0] hit_way;
  logic [WW-1:0] victim_c;
  logic [WW-1:0] victim_way;
  logic          victim_found;
  logic          victim_dirty;
  logic          access_en;
  logic [WW-1:0] access_way;
  logic [OW-1:0] beat;
  logic [OW-1:0] beat_nxt;
  logic          beat_last;
  logic          mem_fire;

  assign req_tag   = addr_q[ADDR_W-1 -: TW];
  assign req_idx   = addr_q[OW +: IW];
  assign req_off   = addr_q[OW-1:0];
  assign beat_nxt  = beat + OW'(1);
  assign beat_last = (beat == OW'(WORDS - 1));
  assign mem_fire  = mem_valid && mem_ready;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (line_valid[req_idx][w] && (line_tag[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
    end
  end

  // Invalid ways are filled lowest-first; otherwise evict the oldest way.
  always_comb begin
    victim_c     = '0;
    victim_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!line_valid[req_idx][w] && !victim_found) begin
        victim_c     = WW'(w);
        victim_found = 1'b1;
      end
    end
    if (!victim_found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (line_age[req_idx][w] == WW'(WAYS - 1)) victim_c = WW'(w);
      end
    end
    victim_dirty = line_valid[req_idx][victim_c] && line_dirty[req_idx][victim_c];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (req_valid) state_nxt = LOOKUP;
      LOOKUP:    if (hit)               state_nxt = IDLE;
                 else if (victim_dirty) state_nxt = WRITEBACK;
                 else                   state_nxt = FILL;
      WRITEBACK: if (mem_fire && beat_last) state_nxt = FILL;
      FILL:      if (mem_fire && beat_last) state_nxt = UPDATE;
      UPDATE:    state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    access_en  = ((state == LOOKUP) && hit) || (state == UPDATE);
    access_way = (state == UPDATE) ? victim_way : hit_way;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      victim_way <= '0;
    end else begin
      if ((state == IDLE) && req_valid) begin
        addr_q  <= req_addr;
        write_q <= req_write;
        wdata_q <= req_wdata;
      end
      if (state == LOOKUP) victim_way <= victim_c;
    end
  end

  // Line status and LRU ages; a touched way becomes youngest, younger ones age.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_valid <= '0;
      line_dirty <= '0;
      line_age   <= {SETS{AGE_ROW}};
    end else begin
      if (state == UPDATE) begin
        line_valid[req_idx][victim_way] <= 1'b1;
        line_dirty[req_idx][victim_way] <= write_q;
      end else if ((state == LOOKUP) && hit && write_q) begin
        line_dirty[req_idx][hit_way] <= 1'b1;
      end
      if (access_en) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WW'(w) == access_way)
            line_age[req_idx][w] <= '0;
          else if (line_age[req_idx][w] < line_age[req_idx][access_way])
            line_age[req_idx][w] <= line_age[req_idx][w] + WW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == UPDATE) line_tag[req_idx][victim_way] <= req_tag;
    if ((state == FILL) && mem_fire) line_data[req_idx][victim_way][beat] <= mem_rdata;
    if (access_en && write_q) line_data[req_idx][access_way][req_off] <= wdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_hit   <= 1'b0;
    end else begin
      resp_valid <= access_en;
      if (access_en) begin
        resp_rdata <= write_q ? wdata_q : line_data[req_idx][access_way][req_off];
        resp_hit   <= (state == LOOKUP);
      end
    end
  end

  // Memory beat registers: loaded one cycle ahead and held until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      beat      <= '0;
    end else begin
      case (state)
        LOOKUP: if (!hit) begin
          beat      <= '0;
          mem_valid <= 1'b1;
          if (victim_dirty) begin
            mem_write <= 1'b1;
            mem_addr  <= {line_tag[req_idx][victim_c], req_idx, {OW{1'b0}}};
            mem_wdata <= line_data[req_idx][victim_c][0];
          end else begin
            mem_write <= 1'b0;
            mem_addr  <= {req_tag, req_idx, {OW{1'b0}}};
          end
        end
        WRITEBACK: if (mem_fire) begin
          if (beat_last) begin
            beat      <= '0;
            mem_write <= 1'b0;
            mem_addr  <= {req_tag, req_idx, {OW{1'b0}}};
          end else begin
            beat      <= beat_nxt;
            mem_addr  <= {line_tag[req_idx][victim_way], req_idx, beat_nxt};
            mem_wdata <= line_data[req_idx][victim_way][beat_nxt];
          end
        end
        FILL: if (mem_fire) begin
          if (beat_last) begin
            mem_valid <= 1'b0;
          end else begin
            beat     <= beat_nxt;
            mem_addr <= {req_tag, req_idx, beat_nxt};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_set_assoc_cache.sv
// Bench for set_assoc_cache: directed table, multi-cycle corner sequences and
// random traffic against a recency-list cache model with its own memory image.
module tb_set_assoc_cache;

  localparam int AW = 13, DW = 16, WORDS = 4, SETS = 64, WAYS = 2;
  localparam int OW = 2, IW = 6;
  localparam int BW = 1 + AW + DW;

  logic          clk, rst;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid, resp_hit;
  logic [DW-1:0] resp_rdata;
  logic          mem_valid, mem_ready, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  set_assoc_cache #(.ADDR_W(AW), .DATA_W(DW), .WORDS(WORDS), .SETS(SETS), .WAYS(WAYS)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_hit(resp_hit),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int stall_n = 0;
  int stamp = 0;

  logic [DW-1:0] mem_model [1 << AW];
  logic [DW-1:0] ref_mem   [1 << AW];
  logic [BW-1:0] exp_q [$];
  assign mem_rdata = mem_model[mem_addr];

  typedef struct {
    int                   set;
    int                   tag;
    bit                   dirty;
    logic [WORDS*DW-1:0]  data;
    int                   used;
  } line_t;
  line_t lines_q [$];

  typedef struct {
    logic [AW-1:0] addr;
    logic          wr;
    logic [DW-1:0] wdata;
    logic          exp_hit;
    logic [DW-1:0] exp_rdata;
    int            exp_lat;
  } vec_t;
  vec_t tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] mk_addr(input int tag, input int set, input int off);
    return AW'((tag << (OW + IW)) | (set << OW) | off);
  endfunction

  // Cache model: lines are kept in a flat list, recency is a use stamp.
  function automatic void model_access(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d,
                                       output logic h, output logic [DW-1:0] rd, output int lat);
    int set, tag, off, idx, lru, cnt;
    line_t ln;
    logic [AW-1:0] ba;
    set = (int'(a) >> OW) % SETS;
    tag = int'(a) >> (OW + IW);
    off = int'(a) % WORDS;
    stamp++;
    idx = -1; lru = -1; cnt = 0;
    for (int i = 0; i < lines_q.size(); i++) begin
      if (lines_q[i].set == set) begin
        cnt++;
        if (lines_q[i].tag == tag) idx = i;
        if (lru < 0 || lines_q[i].used < lines_q[lru].used) lru = i;
      end
    end
    if (idx >= 0) begin
      h = 1'b1;
      lat = 2;
    end else begin
      h = 1'b0;
      lat = WORDS + 3 + WORDS * stall_n;
      if (cnt == WAYS) begin
        ln = lines_q[lru];
        if (ln.dirty) begin
          lat += WORDS + WORDS * stall_n;
          for (int b = 0; b < WORDS; b++) begin
            ba = mk_addr(ln.tag, set, b);
            ref_mem[ba] = ln.data[b*DW +: DW];
            exp_q.push_back({1'b1, ba, ln.data[b*DW +: DW]});
          end
        end
        lines_q.delete(lru);
      end
      ln.set = set; ln.tag = tag; ln.dirty = 1'b0; ln.data = '0; ln.used = 0;
      for (int b = 0; b < WORDS; b++) begin
        ba = mk_addr(tag, set, b);
        ln.data[b*DW +: DW] = ref_mem[ba];
        exp_q.push_back({1'b0, ba, ref_mem[ba]});
      end
      lines_q.push_back(ln);
      idx = lines_q.size() - 1;
    end
    ln = lines_q[idx];
    if (w) begin
      ln.data[off*DW +: DW] = d;
      ln.dirty = 1'b1;
      rd = d;
    end else begin
      rd = ln.data[off*DW +: DW];
    end
    ln.used = stamp;
    lines_q[idx] = ln;
  endfunction

  // Memory responder and beat scoreboard, evaluated just after the falling edge.
  int            wait_cnt = 0;
  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_wdata;
  logic          prev_write;
  logic [BW-1:0] e;

  always @(negedge clk) begin
    #1;
    if (rst) begin
      wait_cnt   = 0;
      prev_stall = 1'b0;
      mem_ready  = 1'b1;
    end else begin
      if (prev_stall) begin
        check("stall_mem_valid", 32'(mem_valid), 32'd1);
        check("stall_mem_addr", 32'(mem_addr), 32'(prev_addr));
        check("stall_mem_wdata", 32'(mem_wdata), 32'(prev_wdata));
        check("stall_mem_write", 32'(mem_write), 32'(prev_write));
      end
      if (mem_valid && wait_cnt < stall_n) begin
        mem_ready = 1'b0;
        wait_cnt++;
      end else begin
        mem_ready = 1'b1;
      end
      if (mem_valid && mem_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL beat_unexpected: got write=%0d addr=%0h, required no beat", mem_write, mem_addr);
        end else begin
          e = exp_q.pop_front();
          check("beat_write", 32'(mem_write), 32'(e[BW-1]));
          check("beat_addr", 32'(mem_addr), 32'(e[DW +: AW]));
          if (mem_write) check("beat_wdata", 32'(mem_wdata), 32'(e[DW-1:0]));
          else           check("beat_rdata", 32'(mem_rdata), 32'(e[DW-1:0]));
        end
        if (mem_write) mem_model[mem_addr] = mem_wdata;
        wait_cnt = 0;
      end
      prev_stall = mem_valid && !mem_ready;
      prev_addr  = mem_addr;
      prev_wdata = mem_wdata;
      prev_write = mem_write;
    end
  end

  task automatic do_req(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d,
                        output logic hit_o, output logic [DW-1:0] rd_o, output int lat_o);
    logic eh;
    logic [DW-1:0] ed;
    int el, t;
    hit_o = 1'bx; rd_o = 'x; lat_o = -1;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_write = w; req_wdata = d;
    t = 0;
    while (!req_ready && t < 100) begin @(negedge clk); t++; end
    if (!req_ready) begin
      check("req_ready_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    model_access(a, w, d, eh, ed, el);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = AW'($urandom);
    req_write = 1'($urandom);
    req_wdata = DW'($urandom);
    t = 1;
    while (!resp_valid && t < 400) begin @(negedge clk); t++; end
    check("resp_seen", 32'(resp_valid), 32'd1);
    if (!resp_valid) return;
    check("resp_ready", 32'(req_ready), 32'd1);
    check("resp_hit", 32'(resp_hit), 32'(eh));
    check("resp_rdata", 32'(resp_rdata), 32'(ed));
    check("resp_latency", 32'(t), 32'(el));
    hit_o = resp_hit; rd_o = resp_rdata; lat_o = t;
  endtask

  task automatic model_reset();
    lines_q.delete();
  endtask

  logic          h;
  logic [DW-1:0] r;
  int            l;

  initial begin
    tbl[0] = '{13'h00F, 1'b0, 16'h0000, 1'b0, 16'hA5AA, 7};
    tbl[1] = '{13'h00D, 1'b0, 16'h0000, 1'b1, 16'hA5A8, 2};
    tbl[2] = '{13'h00E, 1'b1, 16'h1234, 1'b1, 16'h1234, 2};
    tbl[3] = '{13'h00E, 1'b0, 16'h0000, 1'b1, 16'h1234, 2};
    tbl[4] = '{13'h10F, 1'b0, 16'h0000, 1'b0, 16'hA4AA, 7};
    tbl[5] = '{13'h20F, 1'b0, 16'h0000, 1'b0, 16'hA7AA, 11};
    tbl[6] = '{13'h00E, 1'b0, 16'h0000, 1'b0, 16'h1234, 7};

    for (int a = 0; a < (1 << AW); a++) begin
      mem_model[a] = DW'(a) ^ 16'hA5A5;
      ref_mem[a]   = DW'(a) ^ 16'hA5A5;
    end

    // Clock/reset
    rst = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_addr = 13'h123; req_wdata = 16'hFFFF;
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", 32'(resp_rdata), 32'd0);
    check("rst_resp_hit", 32'(resp_hit), 32'd0);
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);

    // Directed table
    for (int i = 0; i < 7; i++) begin
      do_req(tbl[i].addr, tbl[i].wr, tbl[i].wdata, h, r, l);
      check($sformatf("tbl%0d_hit", i), 32'(h), 32'(tbl[i].exp_hit));
      check($sformatf("tbl%0d_rdata", i), 32'(r), 32'(tbl[i].exp_rdata));
      check($sformatf("tbl%0d_lat", i), 32'(l), 32'(tbl[i].exp_lat));
    end

    // Dirty miss with every beat stalled three cycles
    do_req(13'h00C, 1'b1, 16'hBEEF, h, r, l);
    do_req(13'h20D, 1'b1, 16'h5555, h, r, l);
    stall_n = 3;
    do_req(13'h30F, 1'b0, 16'h0000, h, r, l);
    check("stall_miss_lat", 32'(l), 32'd35);
    check("stall_miss_rdata", 32'(r), 32'hA6AA);
    stall_n = 0;
    check("stall_beats_drained", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a fill burst
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 13'h01F;
    exp_q.push_back({1'b0, 13'h01C, ref_mem[13'h01C]});
    exp_q.push_back({1'b0, 13'h01D, ref_mem[13'h01D]});
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midfill_mem_valid", 32'(mem_valid), 32'd1);
    check("midfill_mem_addr", 32'(mem_addr), 32'h01E);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("postrst_mem_valid", 32'(mem_valid), 32'd0);
    check("postrst_req_ready", 32'(req_ready), 32'd1);
    check("postrst_resp_valid", 32'(resp_valid), 32'd0);
    repeat (4) begin
      @(negedge clk);
      check("postrst_no_resp", 32'(resp_valid), 32'd0);
    end
    check("postrst_beats_drained", 32'(exp_q.size()), 32'd0);
    model_reset();
    do_req(13'h00F, 1'b0, 16'h0000, h, r, l);
    check("postrst_miss", 32'(h), 32'd0);

    // req_valid held high with alternating hits
    begin
      int k, cyc, last_acc;
      logic pend, eh;
      logic [DW-1:0] ed;
      int el;
      k = 0; cyc = 0; last_acc = 0; pend = 1'b0; eh = 1'b0; ed = '0;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 13'h00C;
      while ((k < 6 || pend) && cyc < 60) begin
        if (resp_valid) begin
          check("b2b_resp_expected", 32'(pend), 32'd1);
          check("b2b_resp_ready", 32'(req_ready), 32'd1);
          check("b2b_hit", 32'(resp_hit), 32'(eh));
          check("b2b_rdata", 32'(resp_rdata), 32'(ed));
          pend = 1'b0;
        end
        if (req_ready && req_valid && k < 6) begin
          if (k > 0) check("b2b_spacing", 32'(cyc - last_acc), 32'd2);
          model_access(req_addr, 1'b0, '0, eh, ed, el);
          pend = 1'b1;
          last_acc = cyc;
          k++;
        end else if (!req_ready) begin
          if (k == 6) req_valid = 1'b0;
          else        req_addr = (req_addr == 13'h00C) ? 13'h00D : 13'h00C;
        end
        @(negedge clk);
        cyc++;
      end
      req_valid = 1'b0;
      check("b2b_complete", 32'(k == 6 && !pend), 32'd1);
    end

    // Random traffic against the model
    for (int i = 0; i < 150; i++) begin
      stall_n = $urandom_range(0, 2);
      do_req(mk_addr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, WORDS - 1)),
             1'($urandom_range(0, 9) < 4), DW'($urandom), h, r, l);
    end
    stall_n = 0;
    repeat (3) @(negedge clk);
    check("final_beats_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
